dot_product_accum: RTL and testbench



---
 rtl/dot_product_accum.sv | 231 +++++++++++++++++++++++
 tb/tb_dot_product_accum.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_accum.sv
// Pipelined multi-pair multiply, registered adder tree and per-vector accumulator.
// Each beat may be signed or unsigned; each vector reports its sum, its beat count and a sticky overflow flag.
module dot_product_accum #(
    parameter int NUM_PAIRS = 5,
    parameter int DWIDTH    = 4,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [2*NUM_PAIRS*DWIDTH-1:0]   in_data,
    input  logic                            in_last,
    input  logic                            signed_mode,
    output logic                            out_valid,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic [CNT_WIDTH-1:0]            out_beats,
    output logic                            out_overflow
);
    localparam int PW = 2 * DWIDTH;
    localparam int T  = $clog2(NUM_PAIRS);
    localparam int SW = PW + T;
    localparam int IW = 2 * NUM_PAIRS * DWIDTH;

    // S0: input register
    logic          s0_vld_d, s0_vld_q;
    logic          s0_last_d, s0_last_q;
    logic          s0_mode_d, s0_mode_q;
    logic [IW-1:0] s0_data_d, s0_data_q;

    always_comb begin
        s0_vld_d  = in_valid;
        s0_last_d = in_last;
        s0_mode_d = signed_mode;
        s0_data_d = in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_vld_q  <= 1'b0;
            s0_last_q <= 1'b0;
            s0_mode_q <= 1'b0;
            s0_data_q <= '0;
        end else begin
            s0_vld_q  <= s0_vld_d;
            s0_last_q <= s0_last_d;
            s0_mode_q <= s0_mode_d;
            s0_data_q <= s0_data_d;
        end
    end

    // S1: products; operands are widened per mode so a PW-bit product is exact
    logic                    s1_vld_d, s1_vld_q;
    logic                    s1_last_d, s1_last_q;
    logic                    s1_mode_d, s1_mode_q;
    logic [NUM_PAIRS*PW-1:0] s1_prod_d, s1_prod_q;
    logic [DWIDTH-1:0]       op_a, op_b;
    logic [PW-1:0]           op_a_ext, op_b_ext;

    always_comb begin
        s1_vld_d  = s0_vld_q;
        s1_last_d = s0_last_q;
        s1_mode_d = s0_mode_q;
        s1_prod_d = '0;
        op_a      = '0;
        op_b      = '0;
        op_a_ext  = '0;
        op_b_ext  = '0;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            op_a     = s0_data_q[(2*i+1)*DWIDTH +: DWIDTH];
            op_b     = s0_data_q[2*i*DWIDTH +: DWIDTH];
            op_a_ext = s0_mode_q ? {{DWIDTH{op_a[DWIDTH-1]}}, op_a} : {{DWIDTH{1'b0}}, op_a};
            op_b_ext = s0_mode_q ? {{DWIDTH{op_b[DWIDTH-1]}}, op_b} : {{DWIDTH{1'b0}}, op_b};
            s1_prod_d[i*PW +: PW] = op_a_ext * op_b_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_mode_q <= 1'b0;
            s1_prod_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_mode_q <= s1_mode_d;
            s1_prod_q <= s1_prod_d;
        end
    end

    // Adder tree: nodes are carried at the final tree width SW. Products are extended once per mode,
    // so the sums wrap identically to the growing per-level widths.
    for (genvar gi = 0; gi <= T; gi++) begin : g_lvl
        localparam int N = (NUM_PAIRS + (1 << gi) - 1) >> gi;
        logic [N*SW-1:0] node;
        logic            lvl_vld;
        logic            lvl_last;
        logic            lvl_mode;

        if (gi == 0) begin : g_leaf
            always_comb begin
                node = '0;
                for (int j = 0; j < N; j++) begin
                    node[j*SW +: SW] = s1_mode_q ? SW'($signed(s1_prod_q[j*PW +: PW]))
                                                 : SW'(s1_prod_q[j*PW +: PW]);
                end
            end
            assign lvl_vld  = s1_vld_q;
            assign lvl_last = s1_last_q;
            assign lvl_mode = s1_mode_q;
        end else begin : g_sum
            localparam int NP = (NUM_PAIRS + (1 << (gi - 1)) - 1) >> (gi - 1);
            logic [NP*SW-1:0] prev;
            logic [N*SW-1:0]  node_d, node_q;
            logic             vld_q, last_q, mode_q;

            assign prev = g_lvl[gi-1].node;

            always_comb begin
                node_d = '0;
                for (int j = 0; j < NP / 2; j++) begin
                    node_d[j*SW +: SW] = prev[2*j*SW +: SW] + prev[(2*j+1)*SW +: SW];
                end
                if (NP % 2 == 1) begin
                    node_d[(N-1)*SW +: SW] = prev[(NP-1)*SW +: SW];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    node_q <= '0;
                    vld_q  <= 1'b0;
                    last_q <= 1'b0;
                    mode_q <= 1'b0;
                end else begin
                    node_q <= node_d;
                    vld_q  <= g_lvl[gi-1].lvl_vld;
                    last_q <= g_lvl[gi-1].lvl_last;
                    mode_q <= g_lvl[gi-1].lvl_mode;
                end
            end

            assign node     = node_q;
            assign lvl_vld  = vld_q;
            assign lvl_last = last_q;
            assign lvl_mode = mode_q;
        end
    end

    logic [SW-1:0] tree_sum;
    logic          tree_vld, tree_last, tree_mode;

    assign tree_sum  = g_lvl[T].node;
    assign tree_vld  = g_lvl[T].lvl_vld;
    assign tree_last = g_lvl[T].lvl_last;
    assign tree_mode = g_lvl[T].lvl_mode;

    // Accumulate stage; the output registers load in the same edge as the final accumulate
    logic [OUT_WIDTH-1:0] acc_d, acc_q;
    logic [CNT_WIDTH-1:0] beats_d, beats_q;
    logic                 ovf_d, ovf_q;
    logic                 first_d, first_q;
    logic                 out_valid_d, out_valid_q;
    logic [OUT_WIDTH-1:0] out_data_d, out_data_q;
    logic [CNT_WIDTH-1:0] out_beats_d, out_beats_q;
    logic                 out_ovf_d, out_ovf_q;
    logic [OUT_WIDTH-1:0] s_ext, acc_sum;
    logic                 carry, add_ovf;

    always_comb begin
        s_ext            = tree_mode ? OUT_WIDTH'($signed(tree_sum)) : OUT_WIDTH'(tree_sum);
        {carry, acc_sum} = {1'b0, acc_q} + {1'b0, s_ext};
        add_ovf          = tree_mode ? ((acc_q[OUT_WIDTH-1] == s_ext[OUT_WIDTH-1]) &&
                                        (acc_sum[OUT_WIDTH-1] != acc_q[OUT_WIDTH-1]))
                                     : carry;
        acc_d       = acc_q;
        beats_d     = beats_q;
        ovf_d       = ovf_q;
        first_d     = first_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;
        if (tree_vld) begin
            if (first_q) begin
                acc_d   = s_ext;
                beats_d = CNT_WIDTH'(1);
                ovf_d   = 1'b0;
            end else begin
                acc_d   = acc_sum;
                beats_d = (beats_q == '1) ? beats_q : beats_q + CNT_WIDTH'(1);
                ovf_d   = ovf_q | add_ovf;
            end
            first_d = tree_last;
            if (tree_last) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_d;
                out_beats_d = beats_d;
                out_ovf_d   = ovf_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            beats_q     <= '0;
            ovf_q       <= 1'b0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            ovf_q       <= ovf_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_beats    = out_beats_q;
    assign out_overflow = out_ovf_q;
endmodule

// File: tb/tb_dot_product_accum.sv
// Directed bench for dot_product_accum: a single-beat vector table plus multi-beat, overflow and reset sequences.
// A default instance and a 12-bit-result instance share the same stimulus.
module tb_dot_product_accum;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [39:0] in_data;
    logic        in_last;
    logic        signed_mode;

    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_beats;
    logic        out_overflow;

    logic        o12_valid;
    logic [11:0] o12_data;
    logic [7:0]  o12_beats;
    logic        o12_ovf;

    dot_product_accum dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_data(out_data), .out_beats(out_beats), .out_overflow(out_overflow)
    );

    dot_product_accum #(.OUT_WIDTH(12)) dut12 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .signed_mode(signed_mode), .out_valid(o12_valid),
        .out_data(o12_data), .out_beats(o12_beats), .out_overflow(o12_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pulses = 0;
    always @(negedge clk) if (out_valid) pulses++;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [39:0] data;
        logic        mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [39:0] d, input logic m, input logic l);
        in_valid    = 1'b1;
        in_data     = d;
        signed_mode = m;
        in_last     = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Polls out_valid for a bounded number of cycles; lat stays -1 if it never arrives.
    task automatic wait_out(input int start, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                lat = cyc - start;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int start, lat, p0;

        vecs[0] = '{40'hFFFFFFFFFF, 1'b0, 32'd1125};
        vecs[1] = '{40'h8787878787, 1'b1, 32'hFFFFFEE8};
        vecs[2] = '{40'h1212121212, 1'b0, 32'd10};
        vecs[3] = '{40'hFFFFFFFFFF, 1'b1, 32'd5};
        vecs[4] = '{40'h8888888888, 1'b1, 32'd320};
        vecs[5] = '{40'hAB89674523, 1'b0, 32'd250};
        vecs[6] = '{40'hAB89674523, 1'b1, 32'd154};
        vecs[7] = '{40'h7F7F7F7F7F, 1'b1, 32'hFFFFFFDD};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; signed_mode = 1'b0;
        idle(3);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", out_data, 32'd0);
        check("reset_beats", 32'(out_beats), 32'd0);
        check("reset_ovf", 32'(out_overflow), 32'd0);
        reset = 1'b0;
        idle(1);

        for (int i = 0; i < 8; i++) begin
            start = cyc;
            send_beat(vecs[i].data, vecs[i].mode, 1'b1);
            wait_out(start, lat);
            $display("vec %0d mode=%0b data=%h -> out=0x%h beats=%0d ovf=%0b lat=%0d",
                     i, vecs[i].mode, vecs[i].data, out_data, out_beats, out_overflow, lat);
            check("vec_latency", lat, 32'd6);
            check("vec_data", out_data, vecs[i].exp);
            check("vec_beats", 32'(out_beats), 32'd1);
            check("vec_ovf", 32'(out_overflow), 32'd0);
            check("vec_data12", 32'(o12_data), {20'd0, vecs[i].exp[11:0]});
            check("vec_ovf12", 32'(o12_ovf), 32'd0);
            idle(1);
        end

        // Three beats with gaps, last on the third
        p0 = pulses;
        send_beat(40'hFFFFFFFFFF, 1'b0, 1'b0);
        idle(2);
        send_beat(40'hFFFFFFFFFF, 1'b0, 1'b0);
        idle(5);
        start = cyc;
        send_beat(40'hFFFFFFFFFF, 1'b0, 1'b1);
        wait_out(start, lat);
        $display("gapped vector -> out=%0d beats=%0d lat=%0d", out_data, out_beats, lat);
        check("gap_early_pulses", pulses - p0, 32'd0);
        check("gap_latency", lat, 32'd6);
        check("gap_data", out_data, 32'd3375);
        check("gap_beats", 32'(out_beats), 32'd3);
        idle(4);
        check("gap_pulse_count", pulses - p0, 32'd1);

        // Unsigned wrap in the 12-bit instance, then a fresh zero vector
        for (int i = 0; i < 3; i++) send_beat(40'hFFFFFFFFFF, 1'b0, 1'b0);
        start = cyc;
        send_beat(40'hFFFFFFFFFF, 1'b0, 1'b1);
        wait_out(start, lat);
        $display("wrap vector -> out12=%0d ovf12=%0b out=%0d", o12_data, o12_ovf, out_data);
        check("wrap_data12", 32'(o12_data), 32'd404);
        check("wrap_ovf12", 32'(o12_ovf), 32'd1);
        check("wrap_beats12", 32'(o12_beats), 32'd4);
        check("wrap_data32", out_data, 32'd4500);
        check("wrap_ovf32", 32'(out_overflow), 32'd0);
        idle(1);
        start = cyc;
        send_beat(40'h0, 1'b0, 1'b1);
        wait_out(start, lat);
        $display("zero vector -> out12=%0d ovf12=%0b", o12_data, o12_ovf);
        check("zero_data12", 32'(o12_data), 32'd0);
        check("zero_ovf12", 32'(o12_ovf), 32'd0);
        check("zero_beats12", 32'(o12_beats), 32'd1);

        // Signed overflow in 12 bits: seven beats of 320
        for (int i = 0; i < 6; i++) send_beat(40'h8888888888, 1'b1, 1'b0);
        start = cyc;
        send_beat(40'h8888888888, 1'b1, 1'b1);
        wait_out(start, lat);
        $display("signed ovf vector -> out12=0x%h ovf12=%0b out=%0d", o12_data, o12_ovf, out_data);
        check("sovf_data12", 32'(o12_data), 32'h8C0);
        check("sovf_ovf12", 32'(o12_ovf), 32'd1);
        check("sovf_beats12", 32'(o12_beats), 32'd7);
        check("sovf_data32", out_data, 32'd2240);
        check("sovf_ovf32", 32'(out_overflow), 32'd0);
        idle(1);

        // Mixed modes within one vector
        send_beat(40'hFFFFFFFFFF, 1'b0, 1'b0);
        start = cyc;
        send_beat(40'hFFFFFFFFFF, 1'b1, 1'b1);
        wait_out(start, lat);
        $display("mixed vector -> out=%0d beats=%0d", out_data, out_beats);
        check("mixed_data", out_data, 32'd1130);
        check("mixed_beats", 32'(out_beats), 32'd2);
        idle(1);

        // Beat-count saturation
        for (int i = 0; i < 299; i++) send_beat(40'h0, 1'b0, 1'b0);
        start = cyc;
        send_beat(40'h0, 1'b0, 1'b1);
        wait_out(start, lat);
        $display("long vector -> beats=%0d out=%0d", out_beats, out_data);
        check("sat_beats", 32'(out_beats), 32'd255);
        check("sat_data", out_data, 32'd0);
        idle(1);

        // Back-to-back single-beat vectors
        start = cyc;
        send_beat(40'hFFFFFFFFFF, 1'b0, 1'b1);
        send_beat(40'h1212121212, 1'b0, 1'b1);
        wait_out(start, lat);
        $display("b2b first -> out=%0d beats=%0d lat=%0d", out_data, out_beats, lat);
        check("b2b_latency", lat, 32'd6);
        check("b2b_data1", out_data, 32'd1125);
        check("b2b_beats1", 32'(out_beats), 32'd1);
        idle(1);
        $display("b2b second -> valid=%0b out=%0d beats=%0d", out_valid, out_data, out_beats);
        check("b2b_valid2", 32'(out_valid), 32'd1);
        check("b2b_data2", out_data, 32'd10);
        check("b2b_beats2", 32'(out_beats), 32'd1);
        idle(2);

        // Reset mid-vector, with a last beat presented during the reset cycle
        send_beat(40'hFFFFFFFFFF, 1'b0, 1'b0);
        send_beat(40'hFFFFFFFFFF, 1'b0, 1'b0);
        idle(2);
        reset = 1'b1; in_valid = 1'b1; in_data = 40'hFFFFFFFFFF; in_last = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        $display("after reset -> valid=%0b out=%0d beats=%0d ovf=%0b", out_valid, out_data, out_beats, out_overflow);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_beats", 32'(out_beats), 32'd0);
        check("rst_ovf", 32'(out_overflow), 32'd0);
        check("rst_data12", 32'(o12_data), 32'd0);
        p0 = pulses;
        idle(12);
        check("rst_no_pulse", pulses - p0, 32'd0);
        start = cyc;
        send_beat(40'hFFFFFFFFFF, 1'b0, 1'b1);
        wait_out(start, lat);
        $display("post-reset vector -> out=%0d beats=%0d lat=%0d", out_data, out_beats, lat);
        check("post_rst_latency", lat, 32'd6);
        check("post_rst_data", out_data, 32'd1125);
        check("post_rst_beats", 32'(out_beats), 32'd1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
